// File: rtl/axi_read_slave.sv
// axi_read_slave: single-outstanding AXI3 read responder over a backdoor-loadable word memory
module axi_read_slave #(
  parameter int BusWidth = 32,
  parameter int TagBits  = 4,
  parameter int MemDepth = 256
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [TagBits-1:0]          ARID,
  input  logic [BusWidth-1:0]         ARADDR,
  input  logic [3:0]                  ARLEN,
  input  logic [1:0]                  ARSIZE,
  input  logic [1:0]                  ARBURST,
  input  logic [1:0]                  ARLOCK,
  input  logic [3:0]                  ARCACHE,
  input  logic [2:0]                  ARPROT,
  input  logic                        ARVALID,
  output logic                        ARREADY,
  output logic [TagBits-1:0]          RID,
  output logic [BusWidth-1:0]         RDATA,
  output logic [1:0]                  RRESP,
  output logic                        RLAST,
  output logic                        RVALID,
  input  logic                        RREADY,
  input  logic                        mem_we,
  input  logic [$clog2(MemDepth)-1:0] mem_waddr,
  input  logic [BusWidth-1:0]         mem_wdata
);
  localparam int LB = $clog2(BusWidth/8);
  localparam int AW = $clog2(MemDepth);
  typedef enum logic {IDLE, DATA} state_t;
  state_t state_q, state_d;
  logic [BusWidth-1:0] mem [MemDepth];
  logic                arready_q;
  logic [TagBits-1:0]  id_q;
  logic [BusWidth-1:0] addr_q, rdata_q;
  logic [3:0]          len_q, cnt_q;
  logic [1:0]          size_q, burst_q, rresp_q;
  logic                rlast_q;
  logic                ar_hs, r_hs, load, dec, slv;
  logic [BusWidth-1:0] bytes, total, nxt_addr, ld_addr, ld_data;
  logic [3:0]          ld_len, ld_cnt;
  logic [1:0]          ld_size, ld_burst, ld_resp;
  logic                unused_ok;
  assign unused_ok = ^{ARLOCK, ARCACHE, ARPROT};
  assign ARREADY = arready_q;
  assign RVALID  = state_q == DATA;
  assign RID     = id_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;
  // Backdoor port: writes land in any state and survive reset.
  always_ff @(posedge ACLK)
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  // Next address, beat-load selection (AR handshake loads beat 0, R handshake loads the next), response and state.
  always_comb begin
    ar_hs    = ARVALID && arready_q;
    r_hs     = (state_q == DATA) && RREADY;
    bytes    = BusWidth'(1) << size_q;
    total    = (BusWidth'(len_q) + BusWidth'(1)) << size_q;
    nxt_addr = burst_q == 2'b00 ? addr_q :
               burst_q == 2'b10 ? (addr_q & ~(total - BusWidth'(1))) | ((addr_q + bytes) & (total - BusWidth'(1))) :
               addr_q + bytes;
    load     = ar_hs || (r_hs && !rlast_q);
    ld_addr  = ar_hs ? ARADDR : nxt_addr;
    ld_len   = ar_hs ? ARLEN : len_q;
    ld_size  = ar_hs ? ARSIZE : size_q;
    ld_burst = ar_hs ? ARBURST : burst_q;
    ld_cnt   = ar_hs ? 4'd0 : cnt_q + 4'd1;
    dec      = |(ld_addr >> (LB + AW));
    slv      = ld_burst == 2'b11 || int'(ld_size) > LB ||
               (ld_burst == 2'b10 && !(ld_len inside {4'd1, 4'd3, 4'd7, 4'd15}));
    ld_resp  = dec ? 2'b11 : slv ? 2'b10 : 2'b00;
    ld_data  = (dec || slv) ? '0 : mem[ld_addr[LB+AW-1:LB]];
    state_d  = state_q == IDLE ? (ar_hs ? DATA : IDLE) : ((r_hs && rlast_q) ? IDLE : DATA);
  end
  // State, request latch and registered beat outputs; outputs hold while no beat is loaded.
  always_ff @(posedge ACLK)
    if (ARESET) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      arready_q <= state_d == IDLE;
      if (ar_hs) begin
        id_q    <= ARID;
        len_q   <= ARLEN;
        size_q  <= ARSIZE;
        burst_q <= ARBURST;
      end
      if (load) begin
        addr_q  <= ld_addr;
        cnt_q   <= ld_cnt;
        rdata_q <= ld_data;
        rresp_q <= ld_resp;
        rlast_q <= ld_cnt == ld_len;
      end
    end
endmodule

// File: tb/tb_axi_read_slave.sv
// tb_axi_read_slave: randomized and directed bursts checked against a behavioural burst model
`timescale 1ns/1ps
module tb_axi_read_slave;
  logic        clk = 0, rst = 1;
  logic [3:0]  arid = 0, arlen = 0, arcache = 0, rid;
  logic [31:0] araddr = 0, rdata, mem_wdata = 0;
  logic [1:0]  arsize = 0, arburst = 0, arlock = 0, rresp;
  logic [2:0]  arprot = 0;
  logic        arvalid = 0, arready, rlast, rvalid, rready = 0, mem_we = 0;
  logic [7:0]  mem_waddr = 0;
  logic [31:0] mdl [256];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  axi_read_slave dut (
    .ACLK(clk), .ARESET(rst), .ARID(arid), .ARADDR(araddr), .ARLEN(arlen), .ARSIZE(arsize),
    .ARBURST(arburst), .ARLOCK(arlock), .ARCACHE(arcache), .ARPROT(arprot), .ARVALID(arvalid),
    .ARREADY(arready), .RID(rid), .RDATA(rdata), .RRESP(rresp), .RLAST(rlast), .RVALID(rvalid),
    .RREADY(rready), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void exp_beat(input logic [31:0] a0, input logic [3:0] len, input logic [1:0] size,
                                   input logic [1:0] bt, input int i, output logic [31:0] d, output logic [1:0] r);
    logic [31:0] bytes, total, base, a;
    logic slv;
    bytes = 32'd1 << size;
    total = (32'(len) + 1) * bytes;
    base  = a0 & ~(total - 1);
    a     = bt == 2'd0 ? a0 : bt == 2'd2 ? base + ((a0 - base + i * bytes) % total) : a0 + i * bytes;
    slv   = bt == 2'd3 || bytes > 4 || (bt == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    r     = (a >> 2) >= 256 ? 2'b11 : slv ? 2'b10 : 2'b00;
    d     = r == 2'b00 ? mdl[a >> 2] : 32'd0;
  endfunction
  task automatic bd_write(input int idx, input logic [31:0] v);
    mem_we = 1; mem_waddr = 8'(idx); mem_wdata = v;
    @(posedge clk); #1;
    mem_we = 0; mdl[idx] = v;
  endtask
  task automatic issue_ar(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len, input logic [1:0] size,
                          input logic [1:0] bt, input bit bd_en, input int bd_idx, input logic [31:0] bd_v, output bit ok);
    int t = 0;
    arid = id; araddr = a; arlen = len; arsize = size; arburst = bt; arvalid = 1;
    arlock = 2'($urandom); arcache = 4'($urandom); arprot = 3'($urandom);
    while (!arready && t < 50) begin @(posedge clk); #1; t++; end
    ok = arready;
    if (!ok) begin check("ar_timeout", 0, 1); arvalid = 0; return; end
    if (bd_en) begin mem_we = 1; mem_waddr = 8'(bd_idx); mem_wdata = bd_v; end
    @(posedge clk); #1;
    arvalid = 0; mem_we = 0;
  endtask
  task automatic do_burst(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len, input logic [1:0] size,
                          input logic [1:0] bt, input int mode, input bit bd_en = 0, input int bd_idx = 0,
                          input logic [31:0] bd_v = 0);
    bit ok, hs;
    int k = 0, c = 0;
    logic [31:0] ed;
    logic [1:0] er;
    issue_ar(id, a, len, size, bt, bd_en, bd_idx, bd_v, ok);
    if (!ok) return;
    while (k <= int'(len) && c < 300) begin
      rready = mode == 0 ? 1'b1 : mode == 1 ? (c % 3 == 0) : 1'($urandom_range(0, 1));
      exp_beat(a, len, size, bt, k, ed, er);
      check("rvalid", rvalid, 1);
      check("arready_busy", arready, 0);
      check("rid", rid, id);
      check("rdata", rdata, ed);
      check("rresp", rresp, er);
      check("rlast", rlast, k == int'(len));
      hs = rready && rvalid;
      @(posedge clk); #1;
      if (hs) k++;
      c++;
    end
    rready = 0;
    if (k <= int'(len)) check("beat_timeout", 0, 1);
    check("rvalid_end", rvalid, 0);
    check("arready_end", arready, 1);
    if (bd_en) mdl[bd_idx] = bd_v;
  endtask
  initial begin
    bit ok;
    logic [31:0] ed, a;
    logic [1:0] er, bt, sz;
    logic [3:0] ln;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", arready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rid", rid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rresp", rresp, 0);
    for (int i = 0; i < 256; i++) bd_write(i, i < 8 ? 32'hA0 + i : $urandom);
    rst = 0;
    check("arready_hold", arready, 0);
    @(posedge clk); #1;
    check("arready_rise", arready, 1);
    do_burst(4'd3, 32'h8, 4'd3, 2'd2, 2'd1, 0);
    do_burst(4'd1, 32'h18, 4'd3, 2'd2, 2'd2, 0);
    do_burst(4'd2, 32'h4, 4'd2, 2'd2, 2'd0, 0);
    do_burst(4'd4, 32'h10, 4'd3, 2'd2, 2'd1, 1);
    do_burst(4'd5, 32'h400, 4'd3, 2'd2, 2'd1, 0);
    do_burst(4'd6, 32'h10, 4'd2, 2'd2, 2'd2, 0);
    do_burst(4'd7, 32'h0, 4'd1, 2'd3, 2'd1, 0);
    do_burst(4'd8, 32'h0, 4'd2, 2'd2, 2'd3, 0);
    do_burst(4'd9, 32'h3F8, 4'd3, 2'd2, 2'd1, 0);
    for (int n = 0; n < 40; n++) begin
      bt = 2'($urandom);
      sz = $urandom_range(0, 3) == 0 ? 2'($urandom) : 2'd2;
      ln = 4'($urandom);
      a  = bt == 2'd2 ? 32'($urandom_range(0, 32'h37F)) :
           $urandom_range(0, 5) == 0 ? 32'h1000 + $urandom_range(0, 32'hFFFF) : 32'($urandom_range(0, 32'h3FF));
      do_burst(4'($urandom), a, ln, sz, bt, 2);
    end
    issue_ar(4'hA, 32'h20, 4'd7, 2'd2, 2'd1, 0, 0, 0, ok);
    if (ok) begin
      rready = 1;
      @(posedge clk); #1;
      exp_beat(32'h20, 4'd7, 2'd2, 2'd1, 1, ed, er);
      check("rst_beat1", rdata, ed);
      rst = 1;
      @(posedge clk); #1;
      rready = 0;
      check("abort_rvalid", rvalid, 0);
      check("abort_arready", arready, 0);
      check("abort_rdata", rdata, 0);
      check("abort_rlast", rlast, 0);
      check("abort_rid", rid, 0);
      rst = 0;
      @(posedge clk); #1;
      check("abort_arready_rise", arready, 1);
    end
    do_burst(4'hB, 32'h0, 4'd7, 2'd2, 2'd1, 0);
    do_burst(4'hC, 32'h100, 4'd15, 2'd2, 2'd1, 2);
    bd_write(2, 32'h11);
    do_burst(4'hD, 32'h8, 4'd0, 2'd2, 2'd0, 0, 1, 2, 32'h22);
    check("bd_model", mdl[2], 32'h22);
    do_burst(4'hE, 32'h8, 4'd1, 2'd2, 2'd0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
